src_dest_seq_reader: RTL and testbench
======================================

Name: src_dest_seq_reader

Overview:
- Consumer end of the KISS src/dst permutation interface.
- Holds the 32-entry src and dst permutation tables produced by the shuffle stage. Then serves them to the ProgPoW loop sequencer as (src, dst) register-index pairs through a valid/ready handshake.
- The src and dst sequences advance independently. Each wraps modulo NUM_REGS, matching the mix-register selection order.

Parameters:
- NUM_REGS, 32, number of table entries; must be a power of two.
- IDX_W, 5, index width, log2(NUM_REGS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_valid  in  1  load entry valid.
- ld_ready  out  1  load entry accepted when high together with ld_valid.
- ld_idx  in  IDX_W  table slot being written.
- ld_src  in  IDX_W  src permutation value for slot ld_idx.
- ld_dst  in  IDX_W  dst permutation value for slot ld_idx.
- ld_last  in  1  final entry of the load; triggers the permutation check.
- req_valid  in  1  sequencer requests the next pair.
- req_ready  out  1  request accepted.
- req_use_src  in  1  1 = consume and advance src; 0 = peek src, dst only.
- resp_valid  out  1  response pair valid.
- resp_ready  in  1  response consumed.
- resp_src  out  IDX_W  src_tab[src_cnt] at acceptance.
- resp_dst  out  IDX_W  dst_tab[dst_cnt] at acceptance.
- tab_ready  out  1  tables loaded and verified.
- tab_err  out  1  last load was not a valid permutation.

Behaviour:
- Reset (sync, active-high) is highest priority:
  - state=EMPTY; src_cnt=dst_cnt=0; src_seen=dst_seen=0.
  - resp_valid=0, resp_src=0, resp_dst=0, tab_ready=0, tab_err=0.
  - Table contents are don't-care.
- States: EMPTY, LOADING, READY, ERROR.
- ld_ready:
  - 1 in EMPTY, LOADING and ERROR.
  - In READY, ld_ready = !resp_valid.
- Load accept (ld_valid && ld_ready):
  - Writes src_tab[ld_idx]=ld_src and dst_tab[ld_idx]=ld_dst.
  - Sets src_seen[ld_src] and dst_seen[ld_dst].
  - Rewriting a slot is allowed: the last write wins, and the seen bits stay set.
- First accepted entry from EMPTY, READY or ERROR:
  - Clears both seen masks before applying that entry.
  - Clears tab_err and tab_ready.
  - Moves to LOADING.
- Accept with ld_last=1 (the masks include that entry's bits):
  - If both masks are all-ones: go to READY, tab_ready=1, src_cnt=dst_cnt=0.
  - Otherwise: go to ERROR, tab_err=1.
  - Same-cycle first+last (single-entry load) follows the same rule. With NUM_REGS>1 the result is ERROR.
- req_ready = (state==READY) && !ld_valid && (!resp_valid || resp_ready). Load has priority over requests.
- Request accept:
  - Next cycle resp_valid=1, resp_src=src_tab[src_cnt], resp_dst=dst_tab[dst_cnt].
  - dst_cnt increments by 1.
  - src_cnt increments by 1 only if req_use_src=1.
  - Both counters wrap NUM_REGS-1 -> 0 (natural IDX_W overflow).
  - Latency: exactly 1 cycle from accept to resp_valid.
- Response hold: resp_valid and the data stay stable until resp_ready.
  - resp_ready without a new accept: resp_valid drops next cycle.
  - resp_ready with a new accept in the same cycle: back-to-back, one pair per cycle, no bubble.
- Requests in EMPTY, LOADING or ERROR are not accepted (req_ready=0) and the counters hold.
- Reset mid-load: the load is discarded and state=EMPTY; a new load must start from scratch.
- Reset with resp_valid=1: the response is dropped.

Test Plan:
- Load identity tables (slot i: src=i, dst=i, ld_last on i=31) -> tab_ready=1 the cycle after the last accept. Three requests with req_use_src=1 -> responses (0,0),(1,1),(2,2), each 1 cycle after its accept.
- Load src_tab[i]=31-i, dst_tab[i]=(i+1)%32. Requests with use_src=1,0,0,1 -> (31,1),(30,2),(30,3),(30,4). After that, src_cnt=2 and dst_cnt=4.
- Identity tables, 33 requests with use_src=1 -> 32nd response (31,31), 33rd response (0,0), confirming wrap.
- Load with dst value 7 written in both slot 3 and slot 9 (value 12 never written) -> tab_err=1, tab_ready=0. req_valid held high -> req_ready stays 0. A valid reload afterwards -> tab_err=0, tab_ready=1.
- Backpressure: resp_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, resp_valid=1 and the data stable throughout. Raising resp_ready -> one new pair per cycle.
- Assert rst after 10 of 32 load entries -> state=EMPTY. Requests are then refused, and the outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/src_dest_seq_reader.sv
// Holds the src/dst permutation tables written by the shuffle stage and serves them
// to the loop sequencer as (src, dst) register-index pairs over a valid/ready handshake.
module src_dest_seq_reader #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [IDX_W-1:0] ld_src,
    input  logic [IDX_W-1:0] ld_dst,
    input  logic             ld_last,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_use_src,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_src,
    output logic [IDX_W-1:0] resp_dst,
    output logic             tab_ready,
    output logic             tab_err
);

    typedef enum logic [1:0] {EMPTY, LOADING, READY, ERROR} state_t;

    state_t              state;
    logic [IDX_W-1:0]    src_tab [NUM_REGS];
    logic [IDX_W-1:0]    dst_tab [NUM_REGS];
    logic [IDX_W-1:0]    src_cnt;
    logic [IDX_W-1:0]    dst_cnt;
    logic [NUM_REGS-1:0] src_seen;
    logic [NUM_REGS-1:0] dst_seen;
    logic [NUM_REGS-1:0] src_seen_nx;
    logic [NUM_REGS-1:0] dst_seen_nx;
    logic                ld_fire;
    logic                req_fire;

    // A pending response blocks reloading so a served pair never mixes two tables.
    assign ld_ready  = (state != READY) || !resp_valid;
    assign req_ready = (state == READY) && !ld_valid && (!resp_valid || resp_ready);
    assign ld_fire   = ld_valid && ld_ready;
    assign req_fire  = req_valid && req_ready;

    // Any load entry arriving outside LOADING starts a fresh table, so the masks restart.
    always_comb begin
        src_seen_nx = (state == LOADING) ? src_seen : '0;
        dst_seen_nx = (state == LOADING) ? dst_seen : '0;
        src_seen_nx[ld_src] = 1'b1;
        dst_seen_nx[ld_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            src_tab[ld_idx] <= ld_src;
            dst_tab[ld_idx] <= ld_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            src_cnt    <= '0;
            dst_cnt    <= '0;
            src_seen   <= '0;
            dst_seen   <= '0;
            resp_valid <= 1'b0;
            resp_src   <= '0;
            resp_dst   <= '0;
            tab_ready  <= 1'b0;
            tab_err    <= 1'b0;
        end else begin
            if (ld_fire) begin
                src_seen <= src_seen_nx;
                dst_seen <= dst_seen_nx;
                if (!ld_last) begin
                    state     <= LOADING;
                    tab_ready <= 1'b0;
                    tab_err   <= 1'b0;
                end else if ((&src_seen_nx) && (&dst_seen_nx)) begin
                    state     <= READY;
                    tab_ready <= 1'b1;
                    tab_err   <= 1'b0;
                    src_cnt   <= '0;
                    dst_cnt   <= '0;
                end else begin
                    state     <= ERROR;
                    tab_ready <= 1'b0;
                    tab_err   <= 1'b1;
                end
            end

            // ld_fire and req_fire are exclusive: req_ready requires !ld_valid.
            if (req_fire) begin
                resp_valid <= 1'b1;
                resp_src   <= src_tab[src_cnt];
                resp_dst   <= dst_tab[dst_cnt];
                dst_cnt    <= dst_cnt + IDX_W'(1);
                if (req_use_src) begin
                    src_cnt <= src_cnt + IDX_W'(1);
                end
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_src_dest_seq_reader.sv
// Scoreboard bench for src_dest_seq_reader: stimulus pushes expected pairs, a monitor
// pops and compares them whenever a response is consumed.
module tb_src_dest_seq_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [4:0] ld_idx = '0;
    logic [4:0] ld_src = '0;
    logic [4:0] ld_dst = '0;
    logic       ld_last = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_use_src = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [4:0] resp_src;
    logic [4:0] resp_dst;
    logic       tab_ready;
    logic       tab_err;

    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];

    src_dest_seq_reader #(.NUM_REGS(32), .IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx),
        .ld_src(ld_src), .ld_dst(ld_dst), .ld_last(ld_last),
        .req_valid(req_valid), .req_ready(req_ready), .req_use_src(req_use_src),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_src(resp_src), .resp_dst(resp_dst),
        .tab_ready(tab_ready), .tab_err(tab_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed when resp_valid && resp_ready at the next edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected got=(%0d,%0d) required=none", resp_src, resp_dst);
            end else begin
                e = exp_q.pop_front();
                check("resp_src", resp_src, e[9:5]);
                check("resp_dst", resp_dst, e[4:0]);
            end
        end
    end

    function automatic int pat_src(input int kind, input int i);
        if (kind == 1) return 31 - i;
        return i;
    endfunction

    function automatic int pat_dst(input int kind, input int i);
        if (kind == 1) return (i + 1) % 32;
        if (kind == 2) begin
            case (i)
                3:       return 7;
                7:       return 3;
                9:       return 7;
                12:      return 9;
                default: return i;
            endcase
        end
        return i;
    endfunction

    task automatic load_entry(input int idx, input int s, input int d, input bit last);
        int n = 0;
        ld_valid = 1'b1;
        ld_idx   = idx[4:0];
        ld_src   = s[4:0];
        ld_dst   = d[4:0];
        ld_last  = last;
        @(negedge clk);
        while (!ld_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!ld_ready) check("ld_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_table(input int kind, input int lo, input bit exp_ok);
        for (int i = lo; i < 32; i++) begin
            load_entry(i, pat_src(kind, i), pat_dst(kind, i), i == 31);
            if (i == lo) check("tab_ready_loading", tab_ready, 0);
        end
        check("tab_ready_after_load", tab_ready, exp_ok);
        check("tab_err_after_load", tab_err, !exp_ok);
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
    endtask

    // Leaves req_valid high so back-to-back calls issue one request per cycle.
    task automatic issue(input bit use_src, input int es, input int ed, output int waited);
        exp_q.push_back({es[4:0], ed[4:0]});
        req_valid   = 1'b1;
        req_use_src = use_src;
        wait_req(waited);
        @(posedge clk);
        #1;
        check("resp_latency", resp_valid, 1);
    endtask

    initial begin
        int w;

        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_tab_ready", tab_ready, 0);
        check("rst_tab_err", tab_err, 0);
        check("rst_resp_src", resp_src, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // Identity tables, three isolated requests.
        load_table(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, i, i, w);
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            check("resp_drop", resp_valid, 0);
        end

        // Reversed src, rotated dst, mixed use_src; the fifth pair shows src_cnt=2, dst_cnt=4.
        load_table(1, 0, 1'b1);
        issue(1'b1, 31, 1, w);
        issue(1'b0, 30, 2, w);
        issue(1'b0, 30, 3, w);
        issue(1'b1, 30, 4, w);
        issue(1'b1, 29, 5, w);
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Wrap: 33 back-to-back requests over identity tables.
        load_table(0, 0, 1'b1);
        for (int i = 0; i < 33; i++) begin
            issue(1'b1, i % 32, i % 32, w);
            if (i > 0) check("b2b_bubble", w, 0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;

        // Duplicate dst value -> ERROR, requests refused, then a valid reload recovers.
        load_table(2, 0, 1'b0);
        req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("err_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load_table(0, 0, 1'b1);

        // Backpressure: the held pair stays stable and further requests wait.
        resp_ready = 1'b0;
        issue(1'b1, 0, 0, w);
        exp_q.push_back({5'd1, 5'd1});
        repeat (4) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 0);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_src", resp_src, 0);
            check("bp_resp_dst", resp_dst, 0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_req(w);
        check("bp_release_wait", w, 0);
        @(posedge clk);
        #1;
        check("bp_release_valid", resp_valid, 1);
        issue(1'b1, 2, 2, w);
        check("bp_b2b_wait", w, 0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a response is pending drops it.
        resp_ready  = 1'b0;
        req_valid   = 1'b1;
        req_use_src = 1'b1;
        wait_req(w);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pend_resp_valid", resp_valid, 1);
        check("pend_resp_src", resp_src, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        check("rstp_resp_valid", resp_valid, 0);
        check("rstp_resp_src", resp_src, 0);
        check("rstp_resp_dst", resp_dst, 0);
        check("rstp_tab_ready", tab_ready, 0);

        // Reset mid-load: the partial load is discarded and must restart from scratch.
        load_table(0, 0, 1'b1);
        for (int i = 0; i < 10; i++) load_entry(i, i, i, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstl_tab_ready", tab_ready, 0);
        check("rstl_tab_err", tab_err, 0);
        check("rstl_ld_ready", ld_ready, 1);
        check("rstl_resp_valid", resp_valid, 0);
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstl_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load_table(0, 10, 1'b0);
        load_table(0, 0, 1'b1);
        issue(1'b1, 0, 0, w);
        req_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
